// File: rtl/grid_sequencer_if.sv
// Bundle of the host handshake, program ROM port and grid broadcast pins of grid_sequencer.
// The master modport is the sequencer; the slave modport is the host/ROM/grid side.
interface grid_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int SP_W    = 4,
    parameter int INSTR_W = 32
);
    logic               start;
    logic [15:0]        gen_limit;
    logic               busy;
    logic               done;
    logic               error;
    logic [15:0]        gen_count;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    next_program_counter;
    logic [SP_W-1:0]    next_stack_pointer;
    logic               global_enable;
    logic               diverge_consensus;

    modport master (
        input  start, gen_limit, rom_data, diverge_consensus,
        output busy, done, error, gen_count, rom_addr, instruction,
               next_program_counter, next_stack_pointer, global_enable
    );

    modport slave (
        output start, gen_limit, rom_data, diverge_consensus,
        input  busy, done, error, gen_count, rom_addr, instruction,
               next_program_counter, next_stack_pointer, global_enable
    );
endinterface

// File: rtl/grid_sequencer.sv
// Central fetch/execute sequencer for the cellular-automaton grid: PC, call stack, generation count.
// Optional GRID_SEQ_STACK_CHECK_EN turns stack over/underflow into a sticky error plus halt.
module grid_sequencer #(
    parameter int PC_W    = 8,
    parameter int SP_W    = 4,
    parameter int INSTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    grid_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BRD  = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_GEN  = 4'hF;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [15:0]        gen_cnt_q, gen_cnt_d;
    logic [15:0]        limit_q, limit_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    stack_q [2**SP_W];
    logic [PC_W-1:0]    stack_d [2**SP_W];

    logic [3:0]         opcode;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    pc_inc;
    logic [SP_W-1:0]    sp_dec;
    logic [15:0]        gen_inc;
    logic               fault;

    assign opcode  = bus.rom_data[INSTR_W-1 -: 4];
    assign target  = bus.rom_data[PC_W-1:0];
    assign pc_inc  = pc_q + PC_W'(1);
    assign sp_dec  = sp_q - SP_W'(1);
    assign gen_inc = gen_cnt_q + 16'd1;

`ifdef GRID_SEQ_STACK_CHECK_EN
    assign fault = ((opcode == OP_CALL) && (sp_q == '1)) ||
                   ((opcode == OP_RET)  && (sp_q == '0));
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        gen_cnt_d = gen_cnt_q;
        limit_d   = limit_q;
        instr_d   = instr_q;
        stack_d   = stack_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = FETCH;
                    pc_d      = '0;
                    sp_d      = '0;
                    gen_cnt_d = '0;
                    limit_d   = (bus.gen_limit == 16'd0) ? 16'd1 : bus.gen_limit;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                instr_d = bus.rom_data;
                state_d = FETCH;
                pc_d    = pc_inc;
                // A faulting CALL/RET leaves pc, sp and the stack untouched.
                if (fault) begin
                    state_d = HALT;
                    pc_d    = pc_q;
                end else begin
                    case (opcode)
                        OP_JMP: pc_d = target;
                        OP_BRD: if (bus.diverge_consensus) pc_d = target;
                        OP_CALL: begin
                            stack_d[sp_q] = pc_inc;
                            sp_d          = sp_q + SP_W'(1);
                            pc_d          = target;
                        end
                        OP_RET: begin
                            sp_d = sp_dec;
                            pc_d = stack_q[sp_dec];
                        end
                        OP_HALT: begin
                            state_d = HALT;
                            pc_d    = pc_q;
                        end
                        OP_GEN: begin
                            gen_cnt_d = gen_inc;
                            pc_d      = '0;
                            sp_d      = '0;
                            if (gen_inc == limit_q) state_d = HALT;
                        end
                        default: ;
                    endcase
                end
            end
            HALT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            sp_q      <= '0;
            gen_cnt_q <= '0;
            limit_q   <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            gen_cnt_q <= gen_cnt_d;
            limit_q   <= limit_d;
            instr_q   <= instr_d;
        end
    end

    // Stack storage survives reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

`ifdef GRID_SEQ_STACK_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if ((state_q == IDLE) && bus.start) error_d = 1'b0;
        else if ((state_q == EXEC) && fault) error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= error_d;
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.busy                 = (state_q != IDLE);
    assign bus.done                 = (state_q == HALT);
    assign bus.global_enable        = (state_q == EXEC);
    assign bus.gen_count            = gen_cnt_q;
    assign bus.rom_addr             = pc_q;
    assign bus.instruction          = (state_q == EXEC) ? bus.rom_data : instr_q;
    assign bus.next_program_counter = (state_q == EXEC) ? pc_d : pc_q;
    assign bus.next_stack_pointer   = (state_q == EXEC) ? sp_d : sp_q;
endmodule

// File: tb/tb_grid_sequencer.sv
// Directed bench for grid_sequencer: synchronous ROM model, one task per scenario.
module tb_grid_sequencer;
    localparam int PC_W    = 8;
    localparam int SP_W    = 4;
    localparam int INSTR_W = 32;
    localparam logic [31:0] NOP = 32'h1000_0055;

    logic clk = 1'b0;
    logic rst;
    logic [INSTR_W-1:0] rom [256];
    int n_cmp = 0;
    int n_fail = 0;

    grid_sequencer_if #(.PC_W(PC_W), .SP_W(SP_W), .INSTR_W(INSTR_W)) bus ();

    grid_sequencer #(.PC_W(PC_W), .SP_W(SP_W), .INSTR_W(INSTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [7:0] tgt);
        return {op, 20'h0, tgt};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = NOP;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.diverge_consensus = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the caller at the negedge of the FETCH cycle (cycle 1 after start).
    task automatic kick(input logic [15:0] limit);
        @(negedge clk);
        bus.gen_limit = limit;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_op(input logic [3:0] op, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.global_enable === 1'b1 && bus.instruction[31:28] === op) found = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.gen_limit = 16'd0;
        bus.diverge_consensus = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", bus.error); end
        n_cmp++; if (bus.global_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", bus.global_enable); end
        n_cmp++; if (bus.rom_addr !== 8'h00) begin n_fail++; $display("FAIL rst_rom_addr: got %h want 00", bus.rom_addr); end
        n_cmp++; if (bus.instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", bus.instruction); end
        rst = 1'b0;
        // Reset mid-run, during the EXEC at cycle 14 (pc 2, one generation done).
        rom[3] = ins(4'hF, 8'h00);
        kick(16'd5);
        repeat (13) @(negedge clk);
        n_cmp++; if (bus.global_enable !== 1'b1) begin n_fail++; $display("FAIL mid_enable: got %b want 1", bus.global_enable); end
        n_cmp++; if (bus.gen_count !== 16'd1) begin n_fail++; $display("FAIL mid_gen: got %0d want 1", bus.gen_count); end
        n_cmp++; if (bus.next_program_counter !== 8'h03) begin n_fail++; $display("FAIL mid_npc: got %h want 03", bus.next_program_counter); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.global_enable !== 1'b0) begin n_fail++; $display("FAIL mrst_enable: got %b want 0", bus.global_enable); end
        n_cmp++; if (bus.gen_count !== 16'd0) begin n_fail++; $display("FAIL mrst_gen: got %0d want 0", bus.gen_count); end
        n_cmp++; if (bus.rom_addr !== 8'h00) begin n_fail++; $display("FAIL mrst_rom_addr: got %h want 00", bus.rom_addr); end
        n_cmp++; if (bus.instruction !== 32'h0) begin n_fail++; $display("FAIL mrst_instr: got %h want 0", bus.instruction); end
        n_cmp++; if (bus.next_program_counter !== 8'h00) begin n_fail++; $display("FAIL mrst_npc: got %h want 00", bus.next_program_counter); end
        n_cmp++; if (bus.next_stack_pointer !== 4'h0) begin n_fail++; $display("FAIL mrst_nsp: got %h want 0", bus.next_stack_pointer); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mrst_done: got %b want 0", bus.done); end
    endtask

    task automatic test_straight();
        int first_en, last_en, n_en, bad_gap, n_done, done_c;
        hard_reset();
        clear_rom();
        rom[2] = ins(4'hF, 8'h00);
        first_en = -1; last_en = -1; n_en = 0; bad_gap = 0; n_done = 0; done_c = -1;
        kick(16'd3);
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            if (bus.global_enable === 1'b1) begin
                if (first_en < 0) first_en = c;
                else if (c - last_en != 2) bad_gap++;
                last_en = c;
                n_en++;
            end
            if (bus.done === 1'b1) begin n_done++; done_c = c; end
            if (c == 19) begin
                n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL halt_busy: got %b want 1", bus.busy); end
            end
            if (c == 20) begin
                n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
            end
        end
        n_cmp++; if (n_en !== 9) begin n_fail++; $display("FAIL straight_enables: got %0d want 9", n_en); end
        n_cmp++; if (first_en !== 2) begin n_fail++; $display("FAIL first_enable_cycle: got %0d want 2", first_en); end
        n_cmp++; if (bad_gap !== 0) begin n_fail++; $display("FAIL enable_spacing: got %0d bad gaps want 0", bad_gap); end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", n_done); end
        n_cmp++; if (done_c !== 19) begin n_fail++; $display("FAIL done_cycle: got %0d want 19", done_c); end
        n_cmp++; if (bus.gen_count !== 16'd3) begin n_fail++; $display("FAIL straight_gen: got %0d want 3", bus.gen_count); end
    endtask

    task automatic test_gen_zero();
        bit found;
        hard_reset();
        clear_rom();
        rom[0] = ins(4'hF, 8'h00);
        kick(16'd0);
        wait_done(10, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL limit0_done: got %b want 1", found); end
        n_cmp++; if (bus.gen_count !== 16'd1) begin n_fail++; $display("FAIL limit0_gen: got %0d want 1", bus.gen_count); end
    endtask

    task automatic test_brd();
        bit found;
        logic [7:0] exp_pc;
        for (int k = 1; k >= 0; k--) begin
            hard_reset();
            clear_rom();
            rom[5] = ins(4'hB, 8'h10);
            rom[6] = ins(4'hE, 8'h00);
            rom[16] = ins(4'hE, 8'h00);
            exp_pc = (k == 1) ? 8'h10 : 8'h06;
            kick(16'd1);
            wait_op(4'hB, 20, found);
            n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL brd_seen: got %b want 1", found); end
            bus.diverge_consensus = (k == 1);
            #1;
            n_cmp++; if (bus.next_program_counter !== exp_pc) begin n_fail++; $display("FAIL brd_npc dc=%0d: got %h want %h", k, bus.next_program_counter, exp_pc); end
            @(negedge clk);
            bus.diverge_consensus = 1'b0;
            n_cmp++; if (bus.rom_addr !== exp_pc) begin n_fail++; $display("FAIL brd_rom_addr dc=%0d: got %h want %h", k, bus.rom_addr, exp_pc); end
            wait_done(10, found);
            n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL brd_done: got %b want 1", found); end
        end
    endtask

    task automatic test_call_ret();
        bit found;
        hard_reset();
        clear_rom();
        rom[3] = ins(4'hC, 8'h20);
        rom[4] = ins(4'hE, 8'h00);
        rom[32] = ins(4'hD, 8'h00);
        kick(16'd1);
        wait_op(4'hC, 20, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL call_seen: got %b want 1", found); end
        n_cmp++; if (bus.next_program_counter !== 8'h20) begin n_fail++; $display("FAIL call_npc: got %h want 20", bus.next_program_counter); end
        n_cmp++; if (bus.next_stack_pointer !== 4'h1) begin n_fail++; $display("FAIL call_nsp: got %h want 1", bus.next_stack_pointer); end
        @(negedge clk);
        n_cmp++; if (bus.rom_addr !== 8'h20) begin n_fail++; $display("FAIL call_rom_addr: got %h want 20", bus.rom_addr); end
        wait_op(4'hD, 4, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL ret_seen: got %b want 1", found); end
        n_cmp++; if (bus.next_program_counter !== 8'h04) begin n_fail++; $display("FAIL ret_npc: got %h want 04", bus.next_program_counter); end
        n_cmp++; if (bus.next_stack_pointer !== 4'h0) begin n_fail++; $display("FAIL ret_nsp: got %h want 0", bus.next_stack_pointer); end
        @(negedge clk);
        n_cmp++; if (bus.rom_addr !== 8'h04) begin n_fail++; $display("FAIL ret_rom_addr: got %h want 04", bus.rom_addr); end
        wait_done(10, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL callret_done: got %b want 1", found); end
    endtask

    task automatic test_stack();
        bit found;
        int n_calls;
        hard_reset();
        clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = ins(4'hC, 8'(i + 1));
        rom[16] = ins(4'hE, 8'h00);
`ifdef GRID_SEQ_STACK_CHECK_EN
        // Underflow first: RET at sp=0 faults without moving pc or sp.
        rom[40] = ins(4'hD, 8'h00);
        rom[0] = ins(4'hA, 8'd40);
        kick(16'd1);
        wait_op(4'hD, 10, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL uflow_seen: got %b want 1", found); end
        n_cmp++; if (bus.next_program_counter !== 8'd40) begin n_fail++; $display("FAIL uflow_npc: got %h want 28", bus.next_program_counter); end
        n_cmp++; if (bus.next_stack_pointer !== 4'h0) begin n_fail++; $display("FAIL uflow_nsp: got %h want 0", bus.next_stack_pointer); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL uflow_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL uflow_error: got %b want 1", bus.error); end
        @(negedge clk);
        n_cmp++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b want 1", bus.error); end
        rom[0] = ins(4'hC, 8'h01);
        kick(16'd1);
        n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL error_clear: got %b want 0", bus.error); end
        n_calls = 0;
        for (int k = 0; k < 16; k++) begin
            wait_op(4'hC, 4, found);
            if (found) n_calls++;
        end
        n_cmp++; if (n_calls !== 16) begin n_fail++; $display("FAIL oflow_calls: got %0d want 16", n_calls); end
        n_cmp++; if (bus.next_stack_pointer !== 4'hF) begin n_fail++; $display("FAIL oflow_nsp: got %h want f", bus.next_stack_pointer); end
        n_cmp++; if (bus.next_program_counter !== 8'h0F) begin n_fail++; $display("FAIL oflow_npc: got %h want 0f", bus.next_program_counter); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL oflow_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL oflow_error: got %b want 1", bus.error); end
`else
        kick(16'd1);
        n_calls = 0;
        for (int k = 0; k < 16; k++) begin
            wait_op(4'hC, 4, found);
            if (found) n_calls++;
        end
        n_cmp++; if (n_calls !== 16) begin n_fail++; $display("FAIL wrap_calls: got %0d want 16", n_calls); end
        n_cmp++; if (bus.next_stack_pointer !== 4'h0) begin n_fail++; $display("FAIL wrap_call_nsp: got %h want 0", bus.next_stack_pointer); end
        n_cmp++; if (bus.next_program_counter !== 8'h10) begin n_fail++; $display("FAIL wrap_call_npc: got %h want 10", bus.next_program_counter); end
        wait_done(6, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b want 1", found); end
        n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL wrap_error: got %b want 0", bus.error); end
        // RET at sp=0 wraps to 15 and pops the return address pushed by the 16th CALL.
        rom[0] = ins(4'hD, 8'h00);
        kick(16'd1);
        wait_op(4'hD, 4, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL uwrap_seen: got %b want 1", found); end
        n_cmp++; if (bus.next_stack_pointer !== 4'hF) begin n_fail++; $display("FAIL uwrap_nsp: got %h want f", bus.next_stack_pointer); end
        n_cmp++; if (bus.next_program_counter !== 8'h10) begin n_fail++; $display("FAIL uwrap_npc: got %h want 10", bus.next_program_counter); end
        n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL uwrap_error: got %b want 0", bus.error); end
`endif
    endtask

    task automatic test_jmp_wrap();
        bit found;
        hard_reset();
        clear_rom();
        rom[0] = ins(4'hA, 8'hFF);
        kick(16'd1);
        wait_op(4'hA, 4, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL jmp_seen: got %b want 1", found); end
        n_cmp++; if (bus.next_program_counter !== 8'hFF) begin n_fail++; $display("FAIL jmp_npc: got %h want ff", bus.next_program_counter); end
        wait_op(4'h1, 4, found);
        n_cmp++; if (bus.next_program_counter !== 8'h00) begin n_fail++; $display("FAIL pc_wrap_npc: got %h want 00", bus.next_program_counter); end
        @(negedge clk);
        n_cmp++; if (bus.rom_addr !== 8'h00) begin n_fail++; $display("FAIL pc_wrap_rom_addr: got %h want 00", bus.rom_addr); end
    endtask

    task automatic test_start_busy();
        bit found;
        hard_reset();
        clear_rom();
        rom[2] = ins(4'hF, 8'h00);
        kick(16'd2);
        repeat (7) @(negedge clk);
        n_cmp++; if (bus.gen_count !== 16'd1) begin n_fail++; $display("FAIL busy_pre_gen: got %0d want 1", bus.gen_count); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.gen_count !== 16'd1) begin n_fail++; $display("FAIL busy_start_gen: got %0d want 1", bus.gen_count); end
        n_cmp++; if (bus.rom_addr !== 8'h01) begin n_fail++; $display("FAIL busy_start_pc: got %h want 01", bus.rom_addr); end
        wait_done(4, found);
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL busy_done: got %b want 1", found); end
        n_cmp++; if (bus.gen_count !== 16'd2) begin n_fail++; $display("FAIL busy_final_gen: got %0d want 2", bus.gen_count); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_gen_zero();
        test_brd();
        test_call_ret();
        test_stack();
        test_jmp_wrap();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
